// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between IF and EX.
// Handles valid/ready handshakes, illegal-instruction flagging, flush,
// JAL redirect to IF and load-use bubbles.
// Optional feature: define RV32M_EN to decode the RV32M multiply/divide group.
// Instruction ID codes (id_instid), 0 = illegal:
//   1 LUI  2 AUIPC 3 JAL  4 JALR  5 BEQ  6 BNE  7 BLT  8 BGE  9 BLTU 10 BGEU
//  11 LB  12 LH   13 LW  14 LBU  15 LHU 16 SB  17 SH  18 SW
//  19 ADDI 20 SLTI 21 SLTIU 22 XORI 23 ORI 24 ANDI 25 SLLI 26 SRLI 27 SRAI
//  28 ADD 29 SUB 30 SLL 31 SLT 32 SLTU 33 XOR 34 SRL 35 SRA 36 OR 37 AND
//  38..45 MUL MULH MULHSU MULHU DIV DIVU REM REMU
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic            id_rs1_vld,
  output logic            id_rs2_vld,
  output logic            id_rd_vld,
  output logic [XLEN-1:0] id_imm,
  output logic [ID_W-1:0] id_instid,
  output logic            id_illegal,
  output logic            jmp_vld,
  output logic [XLEN-1:0] jmp_target
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic {S_RUN, S_STALL} state_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = if_inst[6:0];
  assign f3    = if_inst[14:12];
  assign f7    = if_inst[31:25];
  assign imm_i = XLEN'($signed(if_inst[31:20]));
  assign imm_s = XLEN'($signed({if_inst[31:25], if_inst[11:7]}));
  assign imm_b = XLEN'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({if_inst[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0}));

  logic [5:0]      dec_num;
  logic [2:0]      dec_vld;
  logic [XLEN-1:0] dec_imm;

  // Decode the incoming word into an ID number, field-use triple and immediate
  always_comb begin
    dec_num = 6'd0;
    dec_vld = 3'b000;
    dec_imm = '0;
    case (opc)
      OP_LUI:   begin dec_num = 6'd1; dec_vld = 3'b001; dec_imm = imm_u; end
      OP_AUIPC: begin dec_num = 6'd2; dec_vld = 3'b001; dec_imm = imm_u; end
      OP_JAL:   begin dec_num = 6'd3; dec_vld = 3'b001; dec_imm = imm_j; end
      OP_JALR:  begin
        dec_num = (f3 == 3'b000) ? 6'd4 : 6'd0;
        dec_vld = 3'b101; dec_imm = imm_i;
      end
      OP_BR: begin
        case (f3)
          3'b000:  dec_num = 6'd5;
          3'b001:  dec_num = 6'd6;
          3'b100:  dec_num = 6'd7;
          3'b101:  dec_num = 6'd8;
          3'b110:  dec_num = 6'd9;
          3'b111:  dec_num = 6'd10;
          default: dec_num = 6'd0;
        endcase
        dec_vld = 3'b110; dec_imm = imm_b;
      end
      OP_LOAD: begin
        case (f3)
          3'b000:  dec_num = 6'd11;
          3'b001:  dec_num = 6'd12;
          3'b010:  dec_num = 6'd13;
          3'b100:  dec_num = 6'd14;
          3'b101:  dec_num = 6'd15;
          default: dec_num = 6'd0;
        endcase
        dec_vld = 3'b101; dec_imm = imm_i;
      end
      OP_STORE: begin
        case (f3)
          3'b000:  dec_num = 6'd16;
          3'b001:  dec_num = 6'd17;
          3'b010:  dec_num = 6'd18;
          default: dec_num = 6'd0;
        endcase
        dec_vld = 3'b110; dec_imm = imm_s;
      end
      OP_IMM: begin
        case (f3)
          3'b000:  dec_num = 6'd19;
          3'b010:  dec_num = 6'd20;
          3'b011:  dec_num = 6'd21;
          3'b100:  dec_num = 6'd22;
          3'b110:  dec_num = 6'd23;
          3'b111:  dec_num = 6'd24;
          3'b001:  dec_num = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
          default: dec_num = (f7 == 7'b0000000) ? 6'd26 :
                             (f7 == 7'b0100000) ? 6'd27 : 6'd0;
        endcase
        dec_vld = 3'b101; dec_imm = imm_i;
      end
      OP_REG: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_num = 6'd28;
            3'b001:  dec_num = 6'd30;
            3'b010:  dec_num = 6'd31;
            3'b011:  dec_num = 6'd32;
            3'b100:  dec_num = 6'd33;
            3'b101:  dec_num = 6'd34;
            3'b110:  dec_num = 6'd36;
            default: dec_num = 6'd37;
          endcase
        end else if (f7 == 7'b0100000) begin
          dec_num = (f3 == 3'b000) ? 6'd29 : (f3 == 3'b101) ? 6'd35 : 6'd0;
`ifdef RV32M_EN
        end else if (f7 == 7'b0000001) begin
          dec_num = 6'd38 + 6'(f3);
`endif
        end
        dec_vld = 3'b111;
      end
      default: dec_num = 6'd0;
    endcase
  end

  logic dec_legal;
  logic id_rs1_vld_d, id_rs2_vld_d, id_rd_vld_d;
  logic [XLEN-1:0] id_imm_d;

  assign dec_legal    = (dec_num != 6'd0);
  assign id_rs1_vld_d = dec_legal & dec_vld[2];
  assign id_rs2_vld_d = dec_legal & dec_vld[1];
  assign id_rd_vld_d  = dec_legal & dec_vld[0] & (if_inst[11:7] != 5'd0);
  assign id_imm_d     = dec_legal ? dec_imm : '0;

  state_t          state_q;
  logic [2:0]      stall_cnt_q;
  logic            id_valid_q, id_rs1_vld_q, id_rs2_vld_q, id_rd_vld_q, id_illegal_q;
  logic [XLEN-1:0] id_pc_q, id_imm_q;
  logic [6:0]      id_opcode_q;
  logic [4:0]      id_rs1_q, id_rs2_q, id_rd_q;
  logic [ID_W-1:0] id_instid_q;
  logic            hazard, accept;

  // Load-use hazard: held load's rd is a source of the incoming instruction
  assign hazard = id_valid_q & ex_ready & (id_opcode_q == OP_LOAD) & ~id_illegal_q &
                  id_rd_vld_q & if_valid &
                  ((id_rs1_vld_d & (if_inst[19:15] == id_rd_q)) |
                   (id_rs2_vld_d & (if_inst[24:20] == id_rd_q)));

  assign if_ready   = ~rst & (~id_valid_q | ex_ready) & ~flush & ~hazard & (state_q == S_RUN);
  assign accept     = if_valid & if_ready;
  assign jmp_vld    = accept & (opc == OP_JAL);
  assign jmp_target = if_pc + imm_j;

  // Pipeline register and RUN/STALL control; flush overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      stall_cnt_q  <= 3'd0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_opcode_q  <= 7'd0;
      id_rs1_q     <= 5'd0;
      id_rs2_q     <= 5'd0;
      id_rd_q      <= 5'd0;
      id_rs1_vld_q <= 1'b0;
      id_rs2_vld_q <= 1'b0;
      id_rd_vld_q  <= 1'b0;
      id_imm_q     <= '0;
      id_instid_q  <= '0;
      id_illegal_q <= 1'b0;
    end else if (flush) begin
      id_valid_q  <= 1'b0;
      state_q     <= S_RUN;
      stall_cnt_q <= 3'd0;
    end else if (state_q == S_STALL) begin
      stall_cnt_q <= stall_cnt_q - 3'd1;
      if (stall_cnt_q == 3'd1) state_q <= S_RUN;
    end else if (accept) begin
      id_valid_q   <= 1'b1;
      id_pc_q      <= if_pc;
      id_opcode_q  <= opc;
      id_rs1_q     <= if_inst[19:15];
      id_rs2_q     <= if_inst[24:20];
      id_rd_q      <= if_inst[11:7];
      id_rs1_vld_q <= id_rs1_vld_d;
      id_rs2_vld_q <= id_rs2_vld_d;
      id_rd_vld_q  <= id_rd_vld_d;
      id_imm_q     <= id_imm_d;
      id_instid_q  <= ID_W'(dec_num);
      id_illegal_q <= ~dec_legal;
    end else if (hazard) begin
      id_valid_q <= 1'b0;
      if (LOAD_LAT > 1) begin
        state_q     <= S_STALL;
        stall_cnt_q <= 3'(LOAD_LAT - 1);
      end
    end else if (ex_ready) begin
      id_valid_q <= 1'b0;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_opcode  = id_opcode_q;
  assign id_rs1     = id_rs1_q;
  assign id_rs2     = id_rs2_q;
  assign id_rd      = id_rd_q;
  assign id_rs1_vld = id_rs1_vld_q;
  assign id_rs2_vld = id_rs2_vld_q;
  assign id_rd_vld  = id_rd_vld_q;
  assign id_imm     = id_imm_q;
  assign id_instid  = id_instid_q;
  assign id_illegal = id_illegal_q;

endmodule
